// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states, default reset PC.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, otherwise holds.
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        valid_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (load_en) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= valid_in;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, imem request FSM (FETCH/HOLD/DRAIN) and a one-entry skid
// buffer that parks a word fetched while the pipeline is stalled.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_IFWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  drain_addr, drain_addr_nxt;
    logic [31:0]  skid_instr, skid_instr_nxt;
    logic [31:0]  skid_pc4, skid_pc4_nxt;
    logic         skid_vld, skid_vld_nxt;
    logic [31:0]  pc_plus4;
    logic         xfer;

    logic         id_load, id_flush, id_valid;
    logic [31:0]  id_instr, id_pc4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = ~rst & (state != HOLD);
    // DRAIN keeps presenting the abandoned address until memory answers it.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign xfer      = imem_req & imem_ready;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        skid_vld_nxt   = skid_vld;
        id_load        = 1'b0;
        id_flush       = 1'b0;
        id_instr       = imem_rdata;
        id_pc4         = pc_plus4;
        id_valid       = 1'b1;

        if (branch_taken) begin
            pc_nxt       = word_align(branch_target);
            skid_vld_nxt = 1'b0;
            id_flush     = 1'b1;
            case (state)
                FETCH: begin
                    if (!xfer) begin
                        drain_addr_nxt = pc;
                        state_nxt      = DRAIN;
                    end
                end
                HOLD:    state_nxt = FETCH;
                DRAIN:   if (xfer) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (xfer) begin
                        pc_nxt = pc_plus4;
                        if (PC_IFWrite) begin
                            id_load = 1'b1;
                        end else begin
                            skid_instr_nxt = imem_rdata;
                            skid_pc4_nxt   = pc_plus4;
                            skid_vld_nxt   = 1'b1;
                            state_nxt      = HOLD;
                        end
                    end else if (PC_IFWrite) begin
                        id_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (PC_IFWrite) begin
                        id_load      = 1'b1;
                        id_instr     = skid_instr;
                        id_pc4       = skid_pc4;
                        id_valid     = skid_vld;
                        skid_vld_nxt = 1'b0;
                        state_nxt    = FETCH;
                    end
                end
                DRAIN: begin
                    if (xfer) state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= 32'h0000_0000;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= 32'h0000_0000;
            skid_vld   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
            skid_vld   <= skid_vld_nxt;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load_en     (id_load),
        .flush       (id_flush),
        .instr_in    (id_instr),
        .pc_plus4_in (id_pc4),
        .valid_in    (id_valid),
        .instr       (instr_id),
        .pc_plus4    (pc_plus4_id),
        .valid       (valid_id)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns 32'hC0DE_0000 | addr[15:0].
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        PC_IFWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;

    int total = 0;
    int bad   = 0;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .PC_IFWrite    (PC_IFWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_id      (instr_id),
        .pc_plus4_id   (pc_plus4_id),
        .valid_id      (valid_id)
    );

    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic vld);
        check({tag, ".instr"}, instr_id, ins);
        check({tag, ".pc4"}, pc_plus4_id, p4);
        check({tag, ".valid"}, {31'd0, valid_id}, {31'd0, vld});
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        rst = 1'b1; PC_IFWrite = 1'b1; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b1;
        #12;
        check_req("rst", 1'b0, 32'h0);
        check_id("rst", 32'h0, 32'h0, 1'b0);
        step();
        check_id("rst_hold", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check_req("rel", 1'b1, 32'h0);

        // Streaming with ready tied high
        step(); check_id("s0", 32'hC0DE_0000, 32'h4, 1'b1); check_req("s0", 1'b1, 32'h4);
        step(); check_id("s1", 32'hC0DE_0004, 32'h8, 1'b1); check_req("s1", 1'b1, 32'h8);
        step(); check_id("s2", 32'hC0DE_0008, 32'hC, 1'b1); check_req("s2", 1'b1, 32'hC);
        step(); check_id("s3", 32'hC0DE_000C, 32'h10, 1'b1); check_req("s3", 1'b1, 32'h10);

        // Stall while 0x10 is fetched: word parks in the skid buffer
        PC_IFWrite = 1'b0;
        step(); check_id("h0", 32'hC0DE_000C, 32'h10, 1'b1); check_req("h0", 1'b0, 32'h14);
        step(); check_id("h1", 32'hC0DE_000C, 32'h10, 1'b1); check_req("h1", 1'b0, 32'h14);
        PC_IFWrite = 1'b1;
        step(); check_id("h2", 32'hC0DE_0010, 32'h14, 1'b1); check_req("h2", 1'b1, 32'h14);

        // Branch coinciding with a transfer: word dropped, no drain
        branch_taken = 1'b1; branch_target = 32'h40;
        step(); check_id("bx", 32'h0, 32'h0, 1'b0); check_req("bx", 1'b1, 32'h40);

        // Branch while 0x40 waits for ready: drain then redirect to 0x200
        branch_taken = 1'b0; imem_ready = 1'b0;
        step(); check_id("w0", 32'h0, 32'h0, 1'b0); check_req("w0", 1'b1, 32'h40);
        branch_taken = 1'b1; branch_target = 32'h203;
        step(); check_id("w1", 32'h0, 32'h0, 1'b0); check_req("w1", 1'b1, 32'h40);
        branch_taken = 1'b0;
        step(); check_id("w2", 32'h0, 32'h0, 1'b0); check_req("w2", 1'b1, 32'h40);
        imem_ready = 1'b1;
        step(); check_id("d0", 32'h0, 32'h0, 1'b0); check_req("d0", 1'b1, 32'h200);
        step(); check_id("d1", 32'hC0DE_0200, 32'h204, 1'b1); check_req("d1", 1'b1, 32'h204);

        // Wrap at the top of the address space (target low bits masked)
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step(); check_req("wr0", 1'b1, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step(); check_id("wr1", 32'hC0DE_FFFC, 32'h0, 1'b1); check_req("wr1", 1'b1, 32'h0);

        // Reset in the middle of HOLD
        PC_IFWrite = 1'b0;
        step(); check_req("rh0", 1'b0, 32'h4);
        #2 rst = 1'b1;
        #1;
        check_req("rh1", 1'b0, 32'h0); check_id("rh1", 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b0; PC_IFWrite = 1'b1;
        #1;
        check_req("rh2", 1'b1, 32'h0);
        step(); check_id("rh3", 32'hC0DE_0000, 32'h4, 1'b1); check_req("rh3", 1'b1, 32'h4);

        // Branch out of HOLD goes straight to FETCH at the target
        PC_IFWrite = 1'b0;
        step(); check_req("hb0", 1'b0, 32'h8);
        branch_taken = 1'b1; branch_target = 32'h300;
        step(); check_id("hb1", 32'h0, 32'h0, 1'b0); check_req("hb1", 1'b1, 32'h300);

        // Reset in the middle of DRAIN
        PC_IFWrite = 1'b1; imem_ready = 1'b0; branch_target = 32'h80;
        step(); check_req("rd0", 1'b1, 32'h300);
        branch_taken = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_req("rd1", 1'b0, 32'h0); check_id("rd1", 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b0; imem_ready = 1'b1;
        #1;
        check_req("rd2", 1'b1, 32'h0);
        step(); check_id("rd3", 32'hC0DE_0000, 32'h4, 1'b1); check_req("rd3", 1'b1, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port PC_IFWrite, input, 1, from load-hazard detection; 0 means PC and IF/ID hold.
REQ-005 The module SHALL have port branch_taken, input, 1, redirect and flush request from ID/EX.
REQ-006 The module SHALL have port branch_target, input, 32, redirect address.
REQ-007 The module SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-008 The module SHALL have port imem_addr, output, 32, instruction-memory word address.
REQ-009 The module SHALL have port imem_ready, input, 1, memory response valid; a transfer completes on an edge with imem_req=1 and imem_ready=1.
REQ-010 The module SHALL have port imem_rdata, input, 32, instruction word, valid with imem_ready.
REQ-011 The module SHALL have ports instr_id, output, 32, and pc_plus4_id, output, 32, the IF/ID register contents.
REQ-012 The module SHALL have port valid_id, output, 1, asserted when instr_id holds a real instruction rather than a bubble.

Function
REQ-013 The module SHALL use FSM states FETCH (imem_req=1, imem_addr=pc), HOLD (imem_req=0, fetched word parked in the skid buffer) and DRAIN (imem_req=1, imem_addr=drain_addr, response discarded).
REQ-014 While imem_req=1, imem_addr SHALL stay constant until the transfer completes.
REQ-015 In FETCH, on transfer with PC_IFWrite=1, IF/ID SHALL load {imem_rdata, pc+4, valid=1} and pc SHALL become pc+4; zero added latency.
REQ-016 In FETCH, on transfer with PC_IFWrite=0, the word and pc+4 SHALL go to the skid buffer, pc SHALL become pc+4, the state SHALL become HOLD, and IF/ID SHALL hold.
REQ-017 In FETCH with no transfer, IF/ID SHALL load a bubble (instr 32'h0000_0000, valid 0) if PC_IFWrite=1, else hold.
REQ-018 In HOLD, when PC_IFWrite=1, IF/ID SHALL load the skid buffer with valid=1 and the state SHALL become FETCH; otherwise everything holds.
REQ-019 branch_taken=1 SHALL override PC_IFWrite: IF/ID cleared to bubble, skid buffer discarded, pc set to {branch_target[31:2],2'b00}.
REQ-020 On branch_taken in FETCH with no transfer that edge, drain_addr SHALL capture the old pc and the state SHALL become DRAIN; with a transfer that edge, the word SHALL be dropped and the state SHALL stay FETCH.
REQ-021 In DRAIN, on transfer the data SHALL be dropped and the state SHALL become FETCH; a further branch_taken SHALL only update pc.
REQ-022 From HOLD, branch_taken SHALL go to FETCH.
REQ-023 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-024 While rst=1: pc=RESET_PC, state=FETCH, imem_req=0, instr_id=0, pc_plus4_id=0, valid_id=0, drain_addr=0, skid buffer cleared.
REQ-025 A reset during HOLD or DRAIN SHALL abandon the parked or outstanding fetch; the first request after release SHALL be to RESET_PC.

Structure
REQ-026 Shared package pipeline_pkg SHALL hold the NOP encoding (32'h0), the FSM state enum and the default RESET_PC.
REQ-027 The IF/ID register SHALL be sub-module if_id_reg with load-enable, flush and async reset; the FSM, PC and skid buffer stay at top.

Verification
REQ-028 Reset release, imem_ready tied 1, PC_IFWrite=1 -> addresses 0, 4, 8; valid_id=1 from the second edge, each word appearing one cycle after its address.
REQ-029 PC_IFWrite=0 for 2 cycles during a ready fetch of 0x10 -> HOLD, imem_req=0, IF/ID unchanged; on release, instr_id = word@0x10, next address 0x14.
REQ-030 branch_taken with target 0x203 while a fetch of 0x40 waits 3 cycles for ready -> imem_addr stays 0x40 until ready, data dropped, next address 0x200, valid_id=0 meanwhile.
REQ-031 branch_taken and imem_ready on the same edge -> word dropped, no DRAIN, next address equals the target.
REQ-032 pc at 0xFFFF_FFFC with a transfer -> next address 0x0000_0000.
REQ-033 rst asserted mid-HOLD and mid-DRAIN -> outputs at reset values immediately; first post-reset address is RESET_PC.
